im_load_fetch_ctrl: RTL
=======================

# im_load_fetch_ctrl

Controller that owns the single port of the 4K-word instruction memory and shares it between a program loader and the CPU fetch path. After reset it fills IM from a valid/ready word stream, then releases the CPU, serving one registered fetch per request with 1-cycle latency. It sits between the IM array (synchronous read, 1-cycle latency) and the single-cycle datapath's PC/fetch logic. Misaligned or out-of-range fetches raise a sticky fault.

## Interface
- ADDR_W, 10, word-address width of IM (DEPTH = 2^ADDR_W words)
- NOP_WORD, 32'h0000_0000, instruction returned on a faulting fetch
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- load_valid  input  1  loader word available
- load_data  input  32  loader word
- load_last  input  1  qualifies the final loader word
- load_ready  output  1  controller accepts a loader word this cycle
- reload  input  1  pulse: abandon RUN and restart loading at word 0
- fetch_en  input  1  CPU fetch request
- fetch_pc  input  32  byte address of the instruction
- instr  output  32  fetched instruction, registered
- instr_valid  output  1  instr holds the response to the previous cycle's fetch
- cpu_run  output  1  IM loaded, CPU may execute
- fault  output  1  sticky fetch fault
- load_count  output  ADDR_W+1  words written since the last load start
- im_addr  output  ADDR_W  IM word address
- im_we  output  1  IM write enable
- im_wdata  output  32  IM write data
- im_rdata  input  32  IM read data, valid the cycle after im_addr is presented

## Operation
- States: IDLE, LOAD, RUN, FAULT.
- Reset:
  - state = IDLE.
  - instr = 0, instr_valid = 0, fault = 0, load_count = 0.
  - cpu_run = 0, load_ready = 0, im_we = 0.
- IDLE: moves to LOAD on the next cycle unconditionally.
- LOAD:
  - load_ready = 1.
  - Accept a word when load_valid && load_ready.
  - On accept, drive im_we = 1, im_addr = load_count[ADDR_W-1:0], im_wdata = load_data, and increment load_count.
  - Go to RUN after accepting a word with load_last = 1.
  - Also go to RUN after accepting word DEPTH-1. load_count then reads DEPTH and there is no wrap-around; the final write goes to address DEPTH-1.
  - fetch_en is ignored; instr_valid stays 0.
- RUN:
  - cpu_run = 1.
  - On fetch_en, decode fetch_pc:
    - Fault condition: fetch_pc[1:0] != 0 or fetch_pc[31:ADDR_W+2] != 0.
    - No fault: im_addr = fetch_pc[ADDR_W+1:2]. Next cycle instr = im_rdata and instr_valid = 1.
    - Fault: no IM read. Next cycle instr = NOP_WORD, instr_valid = 1, fault = 1, and state goes to FAULT.
  - Without fetch_en: instr_valid = 0 next cycle and instr holds its value.
- FAULT:
  - cpu_run = 0, fault stays 1, instr_valid = 0.
  - Only rst leaves FAULT; reload is ignored.
- reload in RUN:
  - Next state is LOAD and load_count is cleared to 0.
  - reload wins over a simultaneous fetch_en: no read, no fault check, instr_valid = 0 next cycle.
  - reload in IDLE or LOAD is ignored.
- im_we is asserted only in LOAD on an accepted word. At all other times im_we = 0 and im_addr holds its last value.
- rst asserted in any state, including mid-load or mid-fetch, gives the reset values on the next edge. A fetch in flight returns no instr_valid. IM contents are not cleared.

## Timing
- load_ready is a combinational decode of state (state == LOAD). It is 1 in the second cycle after rst deasserts.
- Load throughput: 1 word per cycle.
- The write for a word accepted at edge N occurs in cycle N (im_we is combinational from the handshake).
- cpu_run rises the cycle after the last word is accepted.
- Fetch latency: fetch_en at cycle N gives instr/instr_valid at cycle N+1. Back-to-back fetches give a response every cycle.
- fault rises in the same cycle as the faulting instr_valid.

## Test plan
- **Load:** reset, stream 0x20080005, 0x21090001, 0xAC090000 with load_last on the third word -> load_ready=1 two cycles after reset; im_we pulses at addresses 0,1,2; load_count=3; cpu_run=1 the next cycle.
- **Fetch sequence:** after the load above, fetch_pc=0x0,0x4,0x8 on consecutive cycles -> instr=0x20080005, 0x21090001, 0xAC090000 with instr_valid=1 each following cycle.
- **Full memory:** stream 1024 words of value i, never asserting load_last -> after word 1023, load_count=1024 and cpu_run=1; fetch 0xFFC returns 1023.
- **Faults:** fetch_pc=0x6 -> next cycle instr=0, instr_valid=1, fault=1, cpu_run=0; subsequent fetch_en and reload are ignored until rst. Repeat with fetch_pc=0x1000, same response.
- **Reload vs fetch:** in RUN, assert reload with fetch_en and fetch_pc=0x4 -> instr_valid=0, state LOAD, load_count=0, load_ready=1; the new word 0x12345678 overwrites address 0.
- **Reset mid-operation:** assert rst after 2 of 5 loader words -> all outputs at reset values next cycle; the reload writes start again at address 0.

Source files
------------

// File: rtl/im_load_fetch_ctrl.sv
// im_load_fetch_ctrl: owns the single IM port. It fills IM from a loader
// stream after reset and then serves CPU fetches with 1-cycle latency.
// Misaligned or out-of-range fetches latch a sticky fault.
module im_load_fetch_ctrl #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  input  logic              fetch_en,
  input  logic [31:0]       fetch_pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              cpu_run,
  output logic              fault,
  output logic [ADDR_W:0]   load_count,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_we,
  output logic [31:0]       im_wdata,
  input  logic [31:0]       im_rdata
);

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FAULT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   load_count_nxt;
  logic [ADDR_W-1:0] addr_hold, addr_nxt;
  logic [31:0]       instr_hold;
  logic              rd_pend_p1;
  logic              vld_nxt, rd_nxt, nop_nxt, fault_nxt;

  // A fetch faults on a non-word-aligned byte address or one beyond IM.
  function automatic logic pc_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc[31:ADDR_W+2] != '0);
  endfunction

  // Next-state decode, IM port steering and handshake outputs.
  always_comb begin
    state_nxt      = state;
    load_count_nxt = load_count;
    addr_nxt       = addr_hold;
    load_ready     = 1'b0;
    cpu_run        = 1'b0;
    im_we          = 1'b0;
    vld_nxt        = 1'b0;
    rd_nxt         = 1'b0;
    nop_nxt        = 1'b0;
    fault_nxt      = fault;
    case (state)
      IDLE: state_nxt = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          im_we          = 1'b1;
          addr_nxt       = load_count[ADDR_W-1:0];
          load_count_nxt = load_count + 1'b1;
          // Stop at the last word or when the array is full; never wrap.
          if (load_last || (load_count == LAST_IDX)) state_nxt = RUN;
        end
      end
      RUN: begin
        cpu_run = 1'b1;
        // reload takes priority: the fetch is dropped without a fault check.
        if (reload) begin
          state_nxt      = LOAD;
          load_count_nxt = '0;
        end else if (fetch_en) begin
          vld_nxt = 1'b1;
          if (pc_fault(fetch_pc)) begin
            nop_nxt   = 1'b1;
            fault_nxt = 1'b1;
            state_nxt = FAULT;
          end else begin
            rd_nxt   = 1'b1;
            addr_nxt = fetch_pc[ADDR_W+1:2];
          end
        end
      end
      FAULT: ;
      default: state_nxt = IDLE;
    endcase
  end

  assign im_addr  = addr_nxt;
  assign im_wdata = load_data;
  // IM read data arrives the cycle after the address; otherwise hold the last response.
  assign instr    = rd_pend_p1 ? im_rdata : instr_hold;

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      load_count  <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      rd_pend_p1  <= 1'b0;
      instr_hold  <= '0;
    end else begin
      state       <= state_nxt;
      load_count  <= load_count_nxt;
      instr_valid <= vld_nxt;
      fault       <= fault_nxt;
      rd_pend_p1  <= rd_nxt;
      instr_hold  <= nop_nxt ? NOP_WORD : instr;
    end
  end

  // IM address holds its last driven value when the port is idle.
  always_ff @(posedge clk) begin
    addr_hold <= addr_nxt;
  end

endmodule
